// File: rtl/channel_outage_ctrl_if.sv
// channel_outage_ctrl_if: control and status bundle between the board inputs and the outage controller.
interface channel_outage_ctrl_if #(
    parameter int CNT_W   = 16,
    parameter int EVCNT_W = 8
);
    logic [1:0]         mode_i;
    logic               manual_i;
    logic               start_i;
    logic [CNT_W-1:0]   clear_len_i;
    logic [CNT_W-1:0]   outage_len_i;
    logic               channel_interrupt_o;
    logic               outage_start_o;
    logic               busy_o;
    logic [EVCNT_W-1:0] outage_cnt_o;

    modport master (
        output mode_i, manual_i, start_i, clear_len_i, outage_len_i,
        input  channel_interrupt_o, outage_start_o, busy_o, outage_cnt_o
    );

    modport slave (
        input  mode_i, manual_i, start_i, clear_len_i, outage_len_i,
        output channel_interrupt_o, outage_start_o, busy_o, outage_cnt_o
    );
endinterface

// File: rtl/channel_outage_ctrl.sv
// channel_outage_ctrl: sequences the channel interrupt to emulate link outages
// in off, manual, one-shot and periodic modes, counting outage events.
module channel_outage_ctrl #(
    parameter int CNT_W   = 16,
    parameter int EVCNT_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    channel_outage_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, OUTAGE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   c_q, c_d, l_q, l_d, cnt_q, cnt_d;
    logic               int_q, int_d, os_q, os_d;
    logic [EVCNT_W-1:0] ev_q, ev_d;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        if (!bus.mode_i[1]) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (bus.start_i) begin
                state_d = CLEAR;
                c_d     = (bus.clear_len_i == '0) ? CNT_W'(1) : bus.clear_len_i;
                l_d     = (bus.outage_len_i == '0) ? CNT_W'(1) : bus.outage_len_i;
                cnt_d   = c_d - CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == CLEAR) begin
            state_d = OUTAGE;
            cnt_d   = l_q - CNT_W'(1);
        end else if (bus.mode_i[0]) begin
            state_d = CLEAR;
            cnt_d   = c_q - CNT_W'(1);
        end else begin
            state_d = IDLE;
        end
        // Interrupt is registered from the next state so it rises on the edge entering OUTAGE.
        int_d = (bus.mode_i == 2'b01) ? bus.manual_i : (state_d == OUTAGE);
        os_d  = int_d & ~int_q;
        ev_d  = (os_d && ev_q != '1) ? ev_q + EVCNT_W'(1) : ev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            int_q   <= 1'b0;
            os_q    <= 1'b0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
            os_q    <= os_d;
            ev_q    <= ev_d;
        end
    end

    assign bus.channel_interrupt_o = int_q;
    assign bus.outage_start_o      = os_q;
    assign bus.busy_o              = (state_q != IDLE);
    assign bus.outage_cnt_o        = ev_q;
endmodule

// File: tb/tb_channel_outage_ctrl.sv
// tb_channel_outage_ctrl: directed scenarios plus randomized traffic against a
// timeline model (start edge, elapsed cycles, latched lengths) of the outage controller.
module tb_channel_outage_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    channel_outage_ctrl_if #(.CNT_W(16), .EVCNT_W(8)) bus ();

    channel_outage_ctrl #(.CNT_W(16), .EVCNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, k = 0;
    int m_ts = 0, m_c = 0, m_l = 0, m_cnt = 0;
    bit m_act = 0, m_int = 0, m_os = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("interrupt", 32'(bus.channel_interrupt_o), 32'(m_int));
        chk("outage_start", 32'(bus.outage_start_o), 32'(m_os));
        chk("busy", 32'(bus.busy_o), 32'(m_act));
        chk("outage_cnt", 32'(bus.outage_cnt_o), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_act = 0; m_int = 0; m_os = 0; m_cnt = 0;
    endtask

    // One clock edge: drive inputs, advance the timeline model, check after the edge.
    task automatic step(input logic [1:0] md, input logic man, input logic st,
                        input logic [15:0] cl, input logic [15:0] ol);
        bit ni;
        bus.mode_i = md; bus.manual_i = man; bus.start_i = st;
        bus.clear_len_i = cl; bus.outage_len_i = ol;
        @(posedge clk);
        k++;
        if (md < 2) begin
            m_act = 0;
            ni = (md == 1) && man;
        end else begin
            if (m_act) begin
                if (k - m_ts == m_c + m_l) begin
                    if (md == 3) m_ts = k;
                    else m_act = 0;
                end
            end else if (st) begin
                m_act = 1; m_ts = k;
                m_c = (cl == 0) ? 1 : int'(cl);
                m_l = (ol == 0) ? 1 : int'(ol);
            end
            ni = m_act && (k - m_ts) >= m_c;
        end
        m_os = ni && !m_int;
        m_int = ni;
        if (m_os && m_cnt < 255) m_cnt++;
        #1 check_all();
    endtask

    initial begin
        bus.mode_i = 0; bus.manual_i = 0; bus.start_i = 0;
        bus.clear_len_i = 0; bus.outage_len_i = 0;
        #12 check_all();
        rst_n = 1'b1;
        // one-shot C=3 L=2; lengths changed after start must not matter
        step(2, 0, 1, 3, 2);
        repeat (6) step(2, 0, 0, 9, 9);
        // periodic C=2 L=1 with start pulses while busy
        step(3, 0, 1, 2, 1);
        for (int i = 0; i < 12; i++) step(3, 0, (i % 3) == 0, 7, 7);
        repeat (4) step(2, 0, 0, 0, 0);
        // zero lengths behave as 1
        step(2, 0, 1, 0, 0);
        repeat (3) step(2, 0, 0, 0, 0);
        // abort during second outage cycle
        step(3, 0, 1, 2, 5);
        repeat (3) step(3, 0, 0, 2, 5);
        repeat (3) step(0, 0, 1, 2, 5);
        // manual mode follows manual_i and saturates the event counter
        for (int i = 0; i < 520; i++) step(1, (i % 2) == 0, 1, 1, 1);
        chk("cnt_saturated", 32'(bus.outage_cnt_o), 32'd255);
        step(1, 0, 0, 0, 0);
        // async reset mid-outage
        step(3, 0, 1, 2, 6);
        repeat (4) step(3, 0, 0, 2, 6);
        chk("pre_reset_interrupt", 32'(bus.channel_interrupt_o), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;
        step(2, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] md;
            r = $urandom_range(0, 15);
            md = (r < 1) ? 2'd0 : (r < 2) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            step(md, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
